// File: rtl/imem_loader_if.sv
// Bus bundle between a byte-stream/boot controller and the instruction-memory loader.
// The master side drives the start request and byte stream; the slave side is the
// loader, which drives the byte handshake, the memory write port and the status flags.
interface imem_loader_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wd;
    logic             core_hold;
    logic             done;
    logic             err;

    modport master (
        output start,
        output word_count,
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wd,
        input  core_hold,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  word_count,
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wd,
        output core_hold,
        output done,
        output err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to consecutive addresses starting at BASE_ADDR, then checks
// a trailing XOR checksum byte. The core is held in reset while a load is running.
// All outputs are registers so they are glitch-free and clear immediately on reset.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Running 8-bit XOR checksum over every payload byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [1:0]       byte_idx_q;
    logic [7:0]       csum_q;
    logic [31:0]      word_q;
    logic [31:0]      addr_q;
    logic             byte_ready_q;
    logic             imem_we_q;
    logic [31:0]      imem_addr_q;
    logic [31:0]      imem_wd_q;
    logic             core_hold_q;
    logic             done_q;
    logic             err_q;

    logic             xfer_d;
    logic [31:0]      word_d;
    logic [7:0]       csum_d;
    logic [CNT_W-1:0] word_cnt_inc_d;

    // Handshake qualifier, next checksum and next word counter value.
    always_comb begin
        xfer_d         = bus.byte_valid & byte_ready_q;
        csum_d         = csum_update(csum_q, bus.byte_data);
        word_cnt_inc_d = word_cnt_q + CNT_ONE;
    end

    // Drop the incoming byte into its little-endian lane of the word being assembled.
    always_comb begin
        word_d = word_q;
        case (byte_idx_q)
            2'd0:    word_d[7:0]   = bus.byte_data;
            2'd1:    word_d[15:8]  = bus.byte_data;
            2'd2:    word_d[23:16] = bus.byte_data;
            2'd3:    word_d[31:24] = bus.byte_data;
            default: word_d        = word_q;
        endcase
    end

    // Loader FSM with all datapath state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            count_q      <= CNT_ZERO;
            word_cnt_q   <= CNT_ZERO;
            byte_idx_q   <= 2'd0;
            csum_q       <= 8'h00;
            word_q       <= 32'h0000_0000;
            addr_q       <= BASE_ADDR;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wd_q    <= 32'h0000_0000;
            core_hold_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q    <= 1'b0;
                    imem_we_q <= 1'b0;
                    if (bus.start) begin
                        count_q    <= bus.word_count;
                        word_cnt_q <= CNT_ZERO;
                        byte_idx_q <= 2'd0;
                        csum_q     <= 8'h00;
                        word_q     <= 32'h0000_0000;
                        addr_q     <= BASE_ADDR;
                        err_q      <= 1'b0;
                        if (bus.word_count == CNT_ZERO) begin
                            // Nothing to load: report completion straight away.
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            byte_ready_q <= 1'b0;
                            core_hold_q  <= 1'b0;
                        end else begin
                            state_q      <= ST_LOAD;
                            byte_ready_q <= 1'b1;
                            core_hold_q  <= 1'b1;
                        end
                    end else begin
                        byte_ready_q <= 1'b0;
                        core_hold_q  <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (xfer_d) begin
                        word_q     <= word_d;
                        csum_q     <= csum_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            // Word complete: present it to memory for one cycle.
                            state_q      <= ST_WRITE;
                            byte_ready_q <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= addr_q;
                            imem_wd_q    <= word_d;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end

                ST_WRITE: begin
                    imem_we_q    <= 1'b0;
                    addr_q       <= addr_q + 32'd4;
                    word_cnt_q   <= word_cnt_inc_d;
                    byte_ready_q <= 1'b1;
                    if (word_cnt_inc_d == count_q) begin
                        state_q <= ST_CHECK;
                    end else begin
                        state_q <= ST_LOAD;
                    end
                end

                ST_CHECK: begin
                    if (xfer_d) begin
                        err_q        <= (bus.byte_data != csum_q);
                        state_q      <= ST_DONE;
                        byte_ready_q <= 1'b0;
                        core_hold_q  <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        state_q <= ST_CHECK;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here.
                    done_q       <= 1'b0;
                    byte_ready_q <= 1'b0;
                    core_hold_q  <= 1'b0;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q      <= ST_IDLE;
                    byte_ready_q <= 1'b0;
                    imem_we_q    <= 1'b0;
                    core_hold_q  <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wd    = imem_wd_q;
    assign bus.core_hold  = core_hold_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: nominal load, bad checksum, zero count,
// byte-valid gaps, start ignored outside IDLE, and asynchronous reset mid-load.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t0          = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic        ready_seen = 1'b0;

    always #5 clk = ~clk;

    imem_loader_if #(.CNT_W(10)) bus ();

    imem_loader #(.BASE_ADDR(32'h0000_0000), .CNT_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Cycle counter for latency checks.
    always @(posedge clk) cyc++;

    // Record memory writes and any cycle where a byte is accepted.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wd);
        end
        if (bus.byte_ready === 1'b1) ready_seen = 1'b1;
    end

    // Hard stop if something wedges.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [9:0] cnt);
        bus.start      = 1'b1;
        bus.word_count = cnt;
        tick();
        bus.start      = 1'b0;
        bus.word_count = 10'h3FF;
        t0 = cyc;
    endtask

    // Offer one byte after 'gap' idle cycles and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hFF;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        n = 0;
        while (bus.byte_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("byte_ready_timeout", 32'd0, 32'd1);
        tick();
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hFF;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("done_pulse", {31'd0, bus.done}, 32'd1);
    endtask

    function automatic logic [7:0] gen_byte(input int k);
        logic [31:0] v;
        v = k * 37 + 5;
        return v[7:0];
    endfunction

    initial begin
        logic [7:0]  nom_bytes [8];
        logic [7:0]  csum;
        logic [31:0] exp_word;

        nom_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        bus.start      = 1'b0;
        bus.word_count = 10'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hFF;

        // ---- Reset state ----
        repeat (2) tick();
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_imem_we",    {31'd0, bus.imem_we},    32'd0);
        check("rst_core_hold",  {31'd0, bus.core_hold},  32'd0);
        check("rst_done",       {31'd0, bus.done},       32'd0);
        check("rst_err",        {31'd0, bus.err},        32'd0);
        check("rst_imem_addr",  bus.imem_addr,           32'h0000_0000);
        check("rst_imem_wd",    bus.imem_wd,             32'h0000_0000);
        rst = 1'b1;
        tick();

        // ---- Nominal two-word load, no gaps ----
        wr_addr.delete();
        wr_data.delete();
        start_load(10'd2);
        check("nom_core_hold_after_start", {31'd0, bus.core_hold},  32'd1);
        check("nom_ready_in_load",         {31'd0, bus.byte_ready}, 32'd1);
        for (int i = 0; i < 8; i++) send_byte(nom_bytes[i], 0);
        send_byte(8'h2A, 0);
        check("nom_done",       {31'd0, bus.done},      32'd1);
        check("nom_latency",    cyc - t0,               32'd11);
        check("nom_hold_done",  {31'd0, bus.core_hold}, 32'd0);
        check("nom_err",        {31'd0, bus.err},       32'd0);
        tick();
        check("nom_done_1cyc",  {31'd0, bus.done},      32'd0);
        check("nom_nwrites",    wr_addr.size(),         32'd2);
        check("nom_addr0",      wr_addr[0],             32'h0000_0000);
        check("nom_data0",      wr_data[0],             32'h1234_5678);
        check("nom_addr1",      wr_addr[1],             32'h0000_0004);
        check("nom_data1",      wr_data[1],             32'hDEAD_BEEF);
        check("nom_addr_hold",  bus.imem_addr,          32'h0000_0004);
        check("nom_wd_hold",    bus.imem_wd,            32'hDEAD_BEEF);

        // ---- Bad checksum; start pulsed in DONE must be ignored ----
        wr_addr.delete();
        wr_data.delete();
        start_load(10'd2);
        for (int i = 0; i < 8; i++) send_byte(nom_bytes[i], 0);
        send_byte(8'h2B, 0);
        wait_done();
        check("bad_err", {31'd0, bus.err}, 32'd1);
        bus.start      = 1'b1;
        bus.word_count = 10'd0;
        tick();
        bus.start      = 1'b0;
        check("bad_start_in_done_done", {31'd0, bus.done}, 32'd0);
        check("bad_start_in_done_err",  {31'd0, bus.err},  32'd1);
        repeat (3) tick();
        check("bad_err_hold",   {31'd0, bus.err}, 32'd1);
        check("bad_nwrites",    wr_addr.size(),   32'd2);
        check("bad_data0",      wr_data[0],       32'h1234_5678);
        check("bad_data1",      wr_data[1],       32'hDEAD_BEEF);

        // ---- Zero count ----
        wr_addr.delete();
        wr_data.delete();
        ready_seen = 1'b0;
        start_load(10'd0);
        check("zero_done",      {31'd0, bus.done},      32'd1);
        check("zero_err_clr",   {31'd0, bus.err},       32'd0);
        check("zero_core_hold", {31'd0, bus.core_hold}, 32'd0);
        tick();
        check("zero_done_1cyc", {31'd0, bus.done},      32'd0);
        repeat (3) tick();
        check("zero_nwrites",   wr_addr.size(),         32'd0);
        check("zero_ready",     {31'd0, ready_seen},    32'd0);

        // ---- 16 words, first gap-free then with random valid gaps ----
        for (int run = 0; run < 2; run++) begin
            wr_addr.delete();
            wr_data.delete();
            csum = 8'h00;
            start_load(10'd16);
            for (int k = 0; k < 64; k++) begin
                csum = csum ^ gen_byte(k);
                send_byte(gen_byte(k), (run == 0) ? 0 : int'($urandom_range(0, 5)));
            end
            send_byte(csum, (run == 0) ? 0 : int'($urandom_range(0, 5)));
            wait_done();
            check("bp_err",     {31'd0, bus.err}, 32'd0);
            check("bp_nwrites", wr_addr.size(),   32'd16);
            for (int w = 0; w < 16; w++) begin
                exp_word = {gen_byte(4*w+3), gen_byte(4*w+2), gen_byte(4*w+1), gen_byte(4*w)};
                check("bp_addr", wr_addr[w], 32'(4 * w));
                check("bp_data", wr_data[w], exp_word);
            end
            tick();
        end

        // ---- Start ignored in LOAD, then reset after two bytes ----
        wr_addr.delete();
        wr_data.delete();
        start_load(10'd3);
        send_byte(8'hAA, 0);
        bus.start      = 1'b1;
        bus.word_count = 10'd0;
        tick();
        bus.start      = 1'b0;
        check("ign_core_hold", {31'd0, bus.core_hold},  32'd1);
        check("ign_ready",     {31'd0, bus.byte_ready}, 32'd1);
        check("ign_done",      {31'd0, bus.done},       32'd0);
        send_byte(8'hBB, 0);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("mid_rst_imem_we",    {31'd0, bus.imem_we},    32'd0);
        check("mid_rst_core_hold",  {31'd0, bus.core_hold},  32'd0);
        check("mid_rst_done",       {31'd0, bus.done},       32'd0);
        check("mid_rst_err",        {31'd0, bus.err},        32'd0);
        check("mid_rst_imem_addr",  bus.imem_addr,           32'h0000_0000);
        check("mid_rst_imem_wd",    bus.imem_wd,             32'h0000_0000);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_nwrites", wr_addr.size(), 32'd0);
        start_load(10'd1);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 2);
        send_byte(8'h44, 0);
        wait_done();
        check("restart_err",     {31'd0, bus.err}, 32'd0);
        check("restart_nwrites", wr_addr.size(),   32'd1);
        check("restart_addr",    wr_addr[0],       32'h0000_0000);
        check("restart_data",    wr_data[0],       32'h4433_2211);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, instruction-memory byte address of the first loaded word.
REQ-002 SHALL provide parameter CNT_W, default 10, width of the word-count input and internal word counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  begin a load; honoured only in IDLE.
REQ-007 word_count  input  CNT_W  number of 32-bit words to load; sampled when start is honoured.
REQ-008 byte_valid  input  1  source has a byte on byte_data.
REQ-009 byte_data  input  8  incoming byte stream.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 imem_we  output  1  instruction-memory write strobe.
REQ-012 imem_addr  output  32  instruction-memory byte address.
REQ-013 imem_wd  output  32  instruction-memory write data.
REQ-014 core_hold  output  1  high while a load is in progress; keeps the core in reset.
REQ-015 done  output  1  one-cycle pulse at load completion.
REQ-016 err  output  1  checksum mismatch flag of the last completed load.

Function
REQ-017 SHALL implement states IDLE, LOAD, WRITE, CHECK, DONE.
REQ-018 A byte transfer SHALL occur only in a cycle where byte_valid and byte_ready are both 1; byte_data is ignored otherwise.
REQ-019 IDLE: byte_ready=0. On start=1 it SHALL latch word_count, set the address to BASE_ADDR, clear the word counter, byte index and checksum, clear err, and go to LOAD. If word_count=0 it goes to DONE instead.
REQ-020 LOAD: byte_ready=1. Each transfer places the byte into lane byte_idx, little-endian (first byte to bits [7:0], fourth byte to [31:24]). Each transfer also XORs the byte into the 8-bit checksum. The fourth transfer moves to WRITE.
REQ-021 WRITE: byte_ready=0, imem_we=1 for exactly one cycle, imem_addr = current address, imem_wd = assembled word.
REQ-022 On leaving WRITE the address SHALL increment by 4 (modulo 2^32, wrapping silently) and the word counter by 1. The next state is CHECK if the counter equals the latched count, else LOAD.
REQ-023 CHECK: byte_ready=1. On a transfer, err is set to 1 if the byte differs from the accumulated checksum, else 0, and the state goes to DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE unconditionally.
REQ-025 core_hold SHALL be 1 in LOAD, WRITE and CHECK, and 0 in IDLE and DONE.
REQ-026 start SHALL be ignored in every state except IDLE, including DONE.
REQ-027 err SHALL hold its value from DONE until the next honoured start.
REQ-028 Minimum throughput SHALL be one word per 5 cycles (4 byte cycles + 1 write cycle). There are no idle cycles between WRITE and the next LOAD.
REQ-029 imem_we SHALL be 0 in every state other than WRITE.
REQ-030 imem_addr and imem_wd SHALL be held stable outside WRITE.

Reset
REQ-031 rst=0 SHALL immediately force IDLE and set byte_ready, imem_we, core_hold, done and err to 0, with imem_addr=BASE_ADDR, imem_wd=0, and counters and checksum at 0.
REQ-032 Reset asserted mid-load SHALL abandon the partial word without a write. The next start restarts at BASE_ADDR.

Verification
REQ-033 Reset: assert rst=0 mid-simulation -> all outputs take their REQ-031 values in the same cycle, with no clock edge required.
REQ-034 Nominal: word_count=2, bytes 78 56 34 12 EF BE AD DE, checksum 2A -> two writes: addr 0x0 data 0x12345678, then addr 0x4 data 0xDEADBEEF. Then a done pulse, err=0, core_hold high from the cycle after start until DONE.
REQ-035 Bad checksum: same stream with checksum 2B -> both writes still occur, done pulses, err=1 and holds until the next start.
REQ-036 Zero count: word_count=0, start -> done pulse on the next cycle, no imem_we, byte_ready never 1.
REQ-037 Backpressure: byte_valid toggled randomly (gaps of 0-5 cycles) over 16 words -> written data identical to the gap-free run; no byte lost or duplicated.
REQ-038 Reset mid-load after 2 bytes of word 0 -> no imem_we. A new start with word_count=1 writes to BASE_ADDR. A start pulsed during LOAD is ignored, with no counter or address change.
